// File: rtl/hash_light_stream.sv
// rtl/hash_light_stream.sv - multi-block lightweight hash core with valid/ready input and digest streams
// Absorbs NB-byte blocks, runs ROUNDS rounds per block (one per clock), emits an NB-byte digest.
module hash_light_stream #(
   parameter int              NB     = 4,
   parameter int              ROUNDS = 24,
   parameter logic [8*NB-1:0] IV     = (8*NB)'(32'h34550F14)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [8*NB-1:0] in_data,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [8*NB-1:0] digest,
   output logic            busy
);

   localparam int W  = 8 * NB;
   localparam int RW = $clog2(ROUNDS + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROUND,
      ST_WAIT,
      ST_FINAL,
      ST_OUT
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    s;
   logic [W-1:0]    s_round;
   logic [W-1:0]    s_final;
   logic [RW-1:0]   rnd;
   logic            last_q;
   logic            last_round;
   logic [7:0]      r8;
   logic [7:0]      mix;

   assign in_ready   = (state == ST_IDLE) || (state == ST_WAIT);
   assign busy       = (state != ST_IDLE);
   assign last_round = (rnd == RW'(ROUNDS - 1));
   assign r8         = 8'(rnd);

   // One round and the finalise fold, both computed purely from the current S.
   always_comb begin
      s_round = '0;
      s_final = '0;
      mix     = '0;
      for (int i = 0; i < NB; i++) begin
         mix = s[8*((i+1)%NB) +: 8] ^ IV[8*i +: 8] ^ r8;
         s_round[8*i +: 8] = s[8*i +: 8] + {mix[4:0], mix[7:5]};
         s_final[8*i +: 8] = s[8*i +: 8] ^ s[8*(NB-1-i) +: 8] ^ IV[8*i +: 8];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (in_valid) state_nxt = ST_ROUND;
         ST_ROUND: if (last_round) state_nxt = last_q ? ST_FINAL : ST_WAIT;
         ST_WAIT:  if (in_valid) state_nxt = ST_ROUND;
         ST_FINAL: state_nxt = ST_OUT;
         ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s         <= IV;
         rnd       <= '0;
         last_q    <= 1'b0;
         digest    <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  s      <= IV ^ in_data;
                  last_q <= in_last;
                  rnd    <= '0;
               end
            end
            ST_WAIT: begin
               if (in_valid) begin
                  s      <= s ^ in_data;
                  last_q <= in_last;
                  rnd    <= '0;
               end
            end
            ST_ROUND: begin
               s   <= s_round;
               rnd <= rnd + RW'(1);
            end
            ST_FINAL: begin
               digest    <= s_final;
               out_valid <= 1'b1;
            end
            ST_OUT: begin
               // Reloading IV here lets the next message start cleanly from IDLE.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  s         <= IV;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_light_stream.sv
// tb/tb_hash_light_stream.sv - randomized self-checking bench for hash_light_stream
// Three instances (NB=4/ROUNDS=24, NB=8/ROUNDS=1, NB=8/ROUNDS=256) against a byte-level model.
module tb_hash_light_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv [3];
   logic        il [3];
   logic        ordy [3];
   logic [63:0] id [3];

   logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
   logic [31:0] d0;
   logic [63:0] d1, d2;

   logic        ir [3];
   logic        ov [3];
   logic        bz [3];
   logic [63:0] dg [3];

   int n_tests = 0;
   int n_fail  = 0;

   hash_light_stream #(.NB(4), .ROUNDS(24), .IV(32'h34550F14)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .in_data(id[0][31:0]),
      .in_last(il[0]), .out_valid(ov0), .out_ready(ordy[0]), .digest(d0), .busy(bz0));

   hash_light_stream #(.NB(8), .ROUNDS(1), .IV(64'h3455_0F14_A5C3_7E19)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .in_data(id[1]),
      .in_last(il[1]), .out_valid(ov1), .out_ready(ordy[1]), .digest(d1), .busy(bz1));

   hash_light_stream #(.NB(8), .ROUNDS(256), .IV(64'h3455_0F14_A5C3_7E19)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .in_data(id[2]),
      .in_last(il[2]), .out_valid(ov2), .out_ready(ordy[2]), .digest(d2), .busy(bz2));

   always_comb begin
      ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
      ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
      bz[0] = bz0; bz[1] = bz1; bz[2] = bz2;
      dg[0] = {32'h0, d0}; dg[1] = d1; dg[2] = d2;
   end

   function automatic int nb_of(input int k);
      return (k == 0) ? 4 : 8;
   endfunction

   function automatic int rounds_of(input int k);
      return (k == 0) ? 24 : ((k == 1) ? 1 : 256);
   endfunction

   function automatic logic [63:0] iv_of(input int k);
      return (k == 0) ? 64'h0000_0000_3455_0F14 : 64'h3455_0F14_A5C3_7E19;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte-array reference: absorb each block by XOR, apply the round rule, then fold.
   function automatic logic [63:0] model(input int k, input logic [63:0] blks[$]);
      int          nb     = nb_of(k);
      int          rounds = rounds_of(k);
      logic [63:0] ivv    = iv_of(k);
      int          s [8];
      int          t [8];
      int          ivb [8];
      int          x;
      logic [63:0] d = '0;
      for (int i = 0; i < 8; i++) begin
         ivb[i] = int'(ivv[8*i +: 8]);
         s[i]   = ivb[i];
      end
      for (int j = 0; j < blks.size(); j++) begin
         for (int i = 0; i < nb; i++) s[i] = s[i] ^ int'(blks[j][8*i +: 8]);
         for (int r = 0; r < rounds; r++) begin
            t = s;
            for (int i = 0; i < nb; i++) begin
               x    = t[(i+1) % nb] ^ ivb[i] ^ (r % 256);
               x    = ((x << 3) | (x >> 5)) & 255;
               s[i] = (t[i] + x) % 256;
            end
         end
      end
      for (int i = 0; i < nb; i++) d[8*i +: 8] = 8'(s[i] ^ s[nb-1-i] ^ ivb[i]);
      return d;
   endfunction

   task automatic run_msg(input int k, input logic [63:0] blks[$], input int gap, input int bp,
                          input bit keep, input logic [63:0] nxt);
      int          rounds;
      int          t;
      int          c;
      int          bad_rdy;
      int          bad_busy;
      bit          last;
      logic [63:0] exp_d;
      logic [63:0] held;
      rounds   = rounds_of(k);
      exp_d    = model(k, blks);
      ordy[k]  = (bp == 0);
      bad_busy = 0;
      for (int j = 0; j < blks.size(); j++) begin
         last  = (j == blks.size() - 1);
         iv[k] = 1'b1;
         id[k] = blks[j];
         il[k] = last;
         t = 0;
         while (!ir[k] && t < 2000) begin
            @(negedge clk);
            t++;
         end
         check("accept_ready", 64'(ir[k]), 64'd1);
         @(posedge clk);
         @(negedge clk);
         if (keep && last) begin
            id[k] = nxt;
            il[k] = 1'b1;
         end else begin
            iv[k] = 1'b0;
         end
         bad_rdy = 0;
         for (int n = 0; n < rounds; n++) begin
            if (ir[k]) bad_rdy++;
            if (!bz[k]) bad_busy++;
            @(negedge clk);
         end
         check("ready_low_in_round", 64'(bad_rdy), 64'd0);
         if (!last) begin
            check("wait_ready", 64'(ir[k]), 64'd1);
            for (int g = 0; g < gap; g++) begin
               if (!bz[k]) bad_busy++;
               @(negedge clk);
            end
         end
      end
      check("busy_held", 64'(bad_busy), 64'd0);
      c = rounds;
      while (!ov[k] && c < rounds + 40) begin
         @(negedge clk);
         c++;
      end
      check("latency", 64'(c), 64'(rounds + 1));
      check("digest", dg[k], exp_d);
      held    = dg[k];
      bad_rdy = 0;
      for (int b = 0; b < bp; b++) begin
         if (!ov[k] || dg[k] !== held || ir[k]) bad_rdy++;
         @(negedge clk);
      end
      if (bp > 0) check("backpressure_hold", 64'(bad_rdy), 64'd0);
      ordy[k] = 1'b1;
      @(negedge clk);
      check("out_valid_drop", 64'(ov[k]), 64'd0);
      check("idle_ready", 64'(ir[k]), 64'd1);
      check("idle_busy", 64'(bz[k]), 64'd0);
      check("digest_kept", dg[k], exp_d);
      ordy[k] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] q[$];
      logic [63:0] qb[$];
      logic [63:0] a, b;
      int          k, len;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; il[i] = 1'b0; ordy[i] = 1'b0; id[i] = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ir0), 64'd1);
      check("rst_out_valid", 64'(ov0), 64'd0);
      check("rst_busy", 64'(bz0), 64'd0);
      check("rst_digest", dg[0], 64'd0);
      check("rst_digest8", dg[2], 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      q = '{64'h0};
      run_msg(0, q, 0, 0, 1'b0, 64'h0);
      q = '{64'h01020304, 64'hDEADBEEF, 64'hFFFFFFFF};
      run_msg(0, q, 5, 0, 1'b0, 64'h0);
      q = '{64'($urandom)};
      run_msg(0, q, 0, 10, 1'b0, 64'h0);

      // Abort a message mid-ROUND with an asynchronous reset.
      iv[0] = 1'b1; id[0] = 64'h1234_5678; il[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_reset_busy", 64'(bz0), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_ready", 64'(ir0), 64'd1);
      check("abort_busy", 64'(bz0), 64'd0);
      check("abort_out_valid", 64'(ov0), 64'd0);
      check("abort_digest", dg[0], 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q = '{64'hCAFE_F00D};
      run_msg(0, q, 0, 0, 1'b0, 64'h0);

      q = '{{$urandom, $urandom}, {$urandom, $urandom}, 64'h0};
      run_msg(1, q, 2, 1, 1'b0, 64'h0);
      q = '{64'hFFFF_FFFF_FFFF_FFFF};
      run_msg(1, q, 0, 0, 1'b0, 64'h0);
      q = '{{$urandom, $urandom}, 64'h0123_4567_89AB_CDEF};
      run_msg(2, q, 3, 2, 1'b0, 64'h0);

      // in_valid stays high across OUT; the next block must wait for IDLE.
      a  = 64'($urandom);
      b  = 64'($urandom);
      q  = '{a};
      qb = '{b};
      run_msg(0, q, 0, 3, 1'b1, b);
      run_msg(0, qb, 0, 0, 1'b0, 64'h0);

      for (int it = 0; it < 8; it++) begin
         k   = (it % 4 == 3) ? 2 : int'($urandom_range(0, 1));
         len = int'($urandom_range(1, (k == 2) ? 2 : 4));
         q   = {};
         for (int j = 0; j < len; j++) begin
            a = {$urandom, $urandom};
            if (k == 0) a = a & 64'hFFFF_FFFF;
            q.push_back(a);
         end
         run_msg(k, q, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 64'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
